// File: rtl/fetch_queue_if.sv
// fetch_queue_if: groups the fetch front-end's bus signals.
//   master : fetch_queue side (drives imem_addr, out_*, count)
//   slave  : environment side (instruction memory, execute redirect, decode)
// Signals:
//   imem_addr[63:0]   fetch address to instruction memory
//   imem_instr[31:0]  instruction at imem_addr (same-cycle read)
//   redirect_valid    execute-stage redirect
//   redirect_pc[63:0] redirect target
//   out_valid         head entry valid
//   out_pc[63:0]      PC of head entry
//   out_instr[31:0]   instruction of head entry
//   out_ready         decode accepts head this cycle
//   count             current occupancy
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    logic [63:0]             imem_addr;
    logic [31:0]             imem_instr;
    logic                    redirect_valid;
    logic [63:0]             redirect_pc;
    logic                    out_valid;
    logic [63:0]             out_pc;
    logic [31:0]             out_instr;
    logic                    out_ready;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output imem_addr, out_valid, out_pc, out_instr, count,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_pc, out_instr, count,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front-end ahead of decode.
// Owns the fetch PC, drives instruction memory, buffers {PC, instruction}
// pairs in a DEPTH-entry FIFO and presents the head with valid/ready.
// A redirect flushes the queue and restarts fetch at the (word-aligned) target.
// Ports:
//   clk    : clock, all state updates on rising edge
//   reset  : synchronous active-low reset
//   bus    : fetch_queue_if master modport (imem, redirect, decode handshake)
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [63:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [63:0]   fetch_pc;
    logic [63:0]   out_pc_q;
    logic [31:0]   out_instr_q;
    logic [63:0]   head_pc;
    logic [31:0]   head_instr;
    logic          deq, enq;

    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = (cnt != '0);
    assign bus.out_pc    = out_pc_q;
    assign bus.out_instr = out_instr_q;
    assign bus.count     = cnt;

    always_comb begin
        deq      = (cnt != '0) && bus.out_ready;
        enq      = !bus.redirect_valid && ((cnt < CW'(DEPTH)) || deq);
        rd_next  = rd_ptr + AW'(deq);
        cnt_next = bus.redirect_valid ? '0 : (cnt + CW'(enq) - CW'(deq));
        // Output registers track the post-edge head; when the queue drains
        // and refills in the same edge the new head is the entry being written.
        if (enq && (rd_next == wr_ptr)) begin
            head_pc    = fetch_pc;
            head_instr = bus.imem_instr;
        end else begin
            head_pc    = pc_mem[rd_next];
            head_instr = instr_mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[63:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (enq) begin
                pc_mem[wr_ptr]    <= fetch_pc;
                instr_mem[wr_ptr] <= bus.imem_instr;
                wr_ptr            <= wr_ptr + 1'b1;
                fetch_pc          <= fetch_pc + 64'd4;
            end
            rd_ptr <= rd_next;
            cnt    <= cnt_next;
            if (cnt_next != '0) begin
                out_pc_q    <= head_pc;
                out_instr_q <= head_instr;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue with a queue-based
// reference model of fetch, buffering, redirect and reset behaviour.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [63:0] RPC   = 64'd0;

    logic        clk;
    logic        rst_n;
    logic        rv;
    logic [63:0] rpc;
    logic        ordy;

    int checks;
    int errors;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    assign bus.redirect_valid = rv;
    assign bus.redirect_pc    = rpc;
    assign bus.out_ready      = ordy;
    assign bus.imem_instr     = bus.imem_addr[31:0] ^ 32'hA5A5_0000;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [63:0] q_pc [$];
    logic [31:0] q_in [$];
    logic [63:0] m_pc;
    logic [63:0] m_last_pc;
    logic [31:0] m_last_in;

    function automatic logic [31:0] imem_of(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return lo ^ 32'hA5A5_0000;
    endfunction

    function automatic void model_edge();
        bit d, e;
        if (!rst_n) begin
            q_pc.delete();
            q_in.delete();
            m_pc      = RPC;
            m_last_pc = '0;
            m_last_in = '0;
        end else begin
            d = (q_pc.size() > 0) && ordy;
            e = !rv && ((q_pc.size() < DEPTH) || d);
            if (rv) begin
                q_pc.delete();
                q_in.delete();
                m_pc = rpc & ~64'd3;
            end else begin
                if (d) begin
                    void'(q_pc.pop_front());
                    void'(q_in.pop_front());
                end
                if (e) begin
                    q_pc.push_back(m_pc);
                    q_in.push_back(imem_of(m_pc));
                    m_pc = m_pc + 64'd4;
                end
            end
            if (q_pc.size() > 0) begin
                m_last_pc = q_pc[0];
                m_last_in = q_in[0];
            end
        end
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rv = 1'b0; rpc = '0; ordy = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rv = 1'b1; rpc = 64'h777; ordy = 1'b1;
        cycle();
        cycle();
        checks++;
        if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid); end
        checks++;
        if (bus.out_pc !== 64'd0 || bus.out_instr !== 32'd0) begin
            errors++; $display("FAIL reset_out: got pc %0h instr %0h expected 0 0", bus.out_pc, bus.out_instr);
        end
        checks++;
        if (bus.imem_addr !== RPC) begin errors++; $display("FAIL reset_addr: got %0h expected %0h", bus.imem_addr, RPC); end
    endtask

    task automatic test_free_run();
        do_reset();
        ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * i)) begin
                errors++; $display("FAIL free_run_pc[%0d]: got v=%0b pc=%0h expected v=1 pc=%0h", i, bus.out_valid, bus.out_pc, 4 * i);
            end
            checks++;
            if (bus.count !== 3'd1 || bus.out_instr !== imem_of(64'(4 * i))) begin
                errors++; $display("FAIL free_run_cnt[%0d]: got cnt=%0d instr=%0h expected 1 %0h", i, bus.count, bus.out_instr, imem_of(64'(4 * i)));
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_c;
        do_reset();
        ordy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            exp_c = (i + 1 < 4) ? i + 1 : 4;
            checks++;
            if (bus.count !== 3'(exp_c) || bus.imem_addr !== 64'(4 * exp_c) || bus.out_pc !== 64'd0) begin
                errors++; $display("FAIL bp_fill[%0d]: got cnt=%0d addr=%0h pc=%0h expected %0d %0h 0", i, bus.count, bus.imem_addr, bus.out_pc, exp_c, 4 * exp_c);
            end
        end
        ordy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * k)) begin
                errors++; $display("FAIL bp_drain[%0d]: got v=%0b pc=%0h expected v=1 pc=%0h", k, bus.out_valid, bus.out_pc, 4 * k);
            end
        end
    endtask

    task automatic test_full_enq_deq();
        do_reset();
        ordy = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        ordy = 1'b1;
        cycle();
        ordy = 1'b0;
        checks++;
        if (bus.count !== 3'd4 || bus.out_pc !== 64'h4 || bus.imem_addr !== 64'h14) begin
            errors++; $display("FAIL full_enq_deq: got cnt=%0d pc=%0h addr=%0h expected 4 4 14", bus.count, bus.out_pc, bus.imem_addr);
        end
        cycle();
        checks++;
        if (bus.out_pc !== 64'h4 || bus.imem_addr !== 64'h14 || bus.out_instr !== imem_of(64'h4)) begin
            errors++; $display("FAIL full_hold: got pc=%0h addr=%0h instr=%0h expected 4 14 %0h", bus.out_pc, bus.imem_addr, bus.out_instr, imem_of(64'h4));
        end
    endtask

    task automatic test_redirect();
        do_reset();
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rv = 1'b1; rpc = 64'h1003;
        cycle();
        rv = 1'b0;
        checks++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.imem_addr !== 64'h1000) begin
            errors++; $display("FAIL redirect_flush: got cnt=%0d v=%0b addr=%0h expected 0 0 1000", bus.count, bus.out_valid, bus.imem_addr);
        end
        cycle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h1000) begin
            errors++; $display("FAIL redirect_target: got v=%0b pc=%0h expected 1 1000", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_back_to_back();
        ordy = 1'b1;
        rv = 1'b1; rpc = 64'h200;
        cycle();
        checks++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got cnt=%0d v=%0b expected 0 0", bus.count, bus.out_valid);
        end
        rpc = 64'h300;
        cycle();
        rv = 1'b0; ordy = 1'b0;
        checks++;
        if (bus.count !== '0 || bus.imem_addr !== 64'h300) begin
            errors++; $display("FAIL b2b_second: got cnt=%0d addr=%0h expected 0 300", bus.count, bus.imem_addr);
        end
        cycle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h300) begin
            errors++; $display("FAIL b2b_head: got v=%0b pc=%0h expected 1 300", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ordy = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        rst_n = 1'b0; rv = 1'b1; rpc = 64'h5000;
        cycle();
        rst_n = 1'b1; rv = 1'b0;
        checks++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.imem_addr !== RPC || bus.out_pc !== 64'd0) begin
            errors++; $display("FAIL reset_mid: got cnt=%0d v=%0b addr=%0h pc=%0h expected 0 0 0 0", bus.count, bus.out_valid, bus.imem_addr, bus.out_pc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            rv    = ($urandom_range(0, 7) == 0);
            rpc   = {$urandom, $urandom};
            ordy  = ($urandom_range(0, 2) != 0);
            cycle();
            checks++;
            if (bus.count !== 3'(q_pc.size()) || bus.out_valid !== (q_pc.size() > 0)) begin
                errors++; $display("FAIL rand_occ[%0d]: got cnt=%0d v=%0b expected %0d", i, bus.count, bus.out_valid, q_pc.size());
            end
            checks++;
            if (bus.out_pc !== m_last_pc || bus.out_instr !== m_last_in) begin
                errors++; $display("FAIL rand_head[%0d]: got pc=%0h instr=%0h expected %0h %0h", i, bus.out_pc, bus.out_instr, m_last_pc, m_last_in);
            end
            checks++;
            if (bus.imem_addr !== m_pc) begin
                errors++; $display("FAIL rand_addr[%0d]: got %0h expected %0h", i, bus.imem_addr, m_pc);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; rv = 1'b0; rpc = '0; ordy = 1'b0;
        m_pc = RPC; m_last_pc = '0; m_last_in = '0;
        test_reset();
        test_free_run();
        test_backpressure();
        test_full_enq_deq();
        test_redirect();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
